// File: rtl/cam_pkg.sv
// Shared constants, FSM state type and pixel helper for the camera frame-buffer writer.
package cam_pkg;

  localparam int SRC_W  = 640;
  localparam int SRC_H  = 480;
  localparam int DST_W  = 320;
  localparam int DST_H  = 240;
  localparam int ADDR_W = 17;
  localparam int CNT_W  = 10;
  localparam logic [7:0] THRESH = 8'h48;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_VSYNC = 2'd1,
    WAIT_FRAME = 2'd2,
    CAPTURE    = 2'd3
  } state_e;

  // Inverted ink: bright background maps to 0, dark strokes to full scale.
  function automatic logic [7:0] binarize(input logic [7:0] y, input logic [7:0] thr);
    return (y > thr) ? 8'h00 : 8'hFF;
  endfunction

endpackage

// File: rtl/cam_frame_writer_if.sv
// Camera byte stream, capture control and frame-buffer write bundle.
interface cam_frame_writer_if #(
  parameter int ADDR_W = cam_pkg::ADDR_W
);
  logic              cam_pclk_en;
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
  logic              capture_en;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_wdata;
  logic              frame_done;
  logic              busy;
  logic [7:0]        frame_count;

  modport master (
    output cam_pclk_en, cam_vsync, cam_href, cam_data, capture_en,
    input  fb_we, fb_addr, fb_wdata, frame_done, busy, frame_count
  );

  modport slave (
    input  cam_pclk_en, cam_vsync, cam_href, cam_data, capture_en,
    output fb_we, fb_addr, fb_wdata, frame_done, busy, frame_count
  );
endinterface

// File: rtl/cam_pos_counter.sv
// Tracks byte phase, camera column/row and running row base address; flags
// which strobes carry a stored pixel, end a line, or end the frame.
module cam_pos_counter #(
  parameter int SRC_W  = cam_pkg::SRC_W,
  parameter int SRC_H  = cam_pkg::SRC_H,
  parameter int DST_W  = cam_pkg::DST_W,
  parameter int ADDR_W = cam_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pclk_en_i,
  input  logic              href_i,
  input  logic              vsync_i,
  input  logic              in_capture_i,
  input  logic              start_i,
  output logic              keep_o,
  output logic              line_end_o,
  output logic              frame_end_o,
  output logic [ADDR_W-1:0] addr_o
);
  import cam_pkg::*;

  logic              phase_q;
  logic [CNT_W-1:0]  col_q;
  logic [CNT_W-1:0]  row_q;
  logic [ADDR_W-1:0] base_q;
  logic              href_prev_q;
  logic              vsync_prev_q;

  always_comb begin
    keep_o      = pclk_en_i && in_capture_i && href_i && !phase_q &&
                  (col_q < CNT_W'(SRC_W)) && !col_q[0] &&
                  (row_q < CNT_W'(SRC_H)) && !row_q[0];
    line_end_o  = pclk_en_i && in_capture_i && !href_i && href_prev_q;
    frame_end_o = pclk_en_i && in_capture_i && vsync_i && !vsync_prev_q;
    addr_o      = base_q + ADDR_W'(col_q[CNT_W-1:1]);
  end

  // Column saturates at SRC_W so overlong lines can never wrap back into range.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q      <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      base_q       <= '0;
      href_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else if (pclk_en_i) begin
      href_prev_q  <= href_i;
      vsync_prev_q <= vsync_i;
      if (start_i) begin
        phase_q     <= 1'b0;
        col_q       <= '0;
        row_q       <= '0;
        base_q      <= '0;
        href_prev_q <= 1'b0;
      end else if (in_capture_i) begin
        if (href_i) begin
          phase_q <= !phase_q;
          if (!phase_q && (col_q != CNT_W'(SRC_W))) begin
            col_q <= col_q + CNT_W'(1);
          end
        end else if (href_prev_q) begin
          phase_q <= 1'b0;
          col_q   <= '0;
          if (row_q < CNT_W'(SRC_H)) begin
            row_q <= row_q + CNT_W'(1);
            if (row_q[0]) begin
              base_q <= base_q + ADDR_W'(DST_W);
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/cam_frame_writer.sv
// YUV422 luminance capture with 2:1 decimation into an 8-bit frame buffer.
// Optional build macro CAM_BINARIZE_EN stores thresholded (inverted) pixels.
module cam_frame_writer #(
  parameter int SRC_W  = cam_pkg::SRC_W,
  parameter int SRC_H  = cam_pkg::SRC_H,
  parameter int DST_W  = cam_pkg::DST_W,
  parameter int ADDR_W = cam_pkg::ADDR_W
`ifdef CAM_BINARIZE_EN
  , parameter logic [7:0] THRESH = cam_pkg::THRESH
`endif
) (
  input  logic          Clk,
  input  logic          Reset,
  cam_frame_writer_if.slave bus
);
  import cam_pkg::*;

  state_e            state_q;
  logic              busy_q;
  logic              frame_done_q;
  logic [7:0]        frame_count_q;
  logic              fb_we_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [7:0]        fb_wdata_q;

  logic              in_capture_s;
  logic              start_s;
  logic              keep_s;
  logic              line_end_s;
  logic              frame_end_s;
  logic [ADDR_W-1:0] pix_addr_s;
  logic [7:0]        pix_data_s;

  assign in_capture_s = (state_q == CAPTURE);
  assign start_s      = bus.cam_pclk_en && (state_q == WAIT_FRAME) && !bus.cam_vsync;

  cam_pos_counter #(
    .SRC_W  (SRC_W),
    .SRC_H  (SRC_H),
    .DST_W  (DST_W),
    .ADDR_W (ADDR_W)
  ) u_pos (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .pclk_en_i    (bus.cam_pclk_en),
    .href_i       (bus.cam_href),
    .vsync_i      (bus.cam_vsync),
    .in_capture_i (in_capture_s),
    .start_i      (start_s),
    .keep_o       (keep_s),
    .line_end_o   (line_end_s),
    .frame_end_o  (frame_end_s),
    .addr_o       (pix_addr_s)
  );

`ifdef CAM_BINARIZE_EN
  assign pix_data_s = binarize(bus.cam_data, THRESH);
`else
  assign pix_data_s = bus.cam_data;
`endif

  // Frame sequencing; a line end coinciding with vsync is already absorbed by the counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.cam_pclk_en) begin
        case (state_q)
          IDLE: begin
            if (bus.capture_en) state_q <= WAIT_VSYNC;
          end
          WAIT_VSYNC: begin
            if (bus.cam_vsync) begin
              state_q <= WAIT_FRAME;
              busy_q  <= 1'b1;
            end
          end
          WAIT_FRAME: begin
            if (!bus.cam_vsync) state_q <= CAPTURE;
          end
          CAPTURE: begin
            if (frame_end_s) begin
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 8'd1;
              if (bus.capture_en) begin
                state_q <= WAIT_FRAME;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= 8'd0;
    end else begin
      fb_we_q <= keep_s;
      if (keep_s) begin
        fb_addr_q  <= pix_addr_s;
        fb_wdata_q <= pix_data_s;
      end
    end
  end

  assign bus.fb_we       = fb_we_q;
  assign bus.fb_addr     = fb_addr_q;
  assign bus.fb_wdata    = fb_wdata_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.busy        = busy_q;
  assign bus.frame_count = frame_count_q;

  logic unused_s;
  assign unused_s = line_end_s;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer on a reduced 32x16 camera geometry.
module tb_cam_frame_writer;
  localparam int TW = 32;
  localparam int TH = 16;
  localparam int DW = TW / 2;
  localparam int DH = TH / 2;
  localparam int AW = 8;
`ifdef CAM_BINARIZE_EN
  localparam bit BIN = 1'b1;
`else
  localparam bit BIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_frame_writer_if #(.ADDR_W(AW)) bus();
  cam_frame_writer #(.SRC_W(TW), .SRC_H(TH), .DST_W(DW), .ADDR_W(AW)) dut (
    .Clk(clk), .Reset(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int wr_total = 0;
  int done_total = 0;
  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] last_wa = '0;

  logic          s_we, s_done, s_busy;
  logic [AW-1:0] s_addr;
  logic [7:0]    s_data;

  always @(negedge clk) begin
    if (bus.fb_we === 1'b1) begin
      wr_total = wr_total + 1;
      mem[bus.fb_addr] = bus.fb_wdata;
      last_wa = bus.fb_addr;
    end
    if (bus.frame_done === 1'b1) done_total = done_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One camera byte: strobe high for one Clk, then low for one Clk.
  task automatic strobe(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk);
    bus.cam_vsync = v; bus.cam_href = h; bus.cam_data = d; bus.cam_pclk_en = 1'b1;
    @(negedge clk); #1;
    bus.cam_pclk_en = 1'b0;
    s_we = bus.fb_we; s_addr = bus.fb_addr; s_data = bus.fb_wdata;
    s_done = bus.frame_done; s_busy = bus.busy;
  endtask

  task automatic send_line(input int n_y, input logic [7:0] y);
    for (int i = 0; i < n_y; i++) begin
      strobe(1'b0, 1'b1, y);
      strobe(1'b0, 1'b1, 8'h80);
    end
    strobe(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_open();
    strobe(1'b1, 1'b0, 8'h00);
    strobe(1'b1, 1'b0, 8'h00);
    strobe(1'b0, 1'b0, 8'h00);
  endtask

  typedef struct {
    logic [7:0] y;
    logic [7:0] y_odd;
    logic [7:0] addr;
    logic [7:0] raw_exp;
    logic [7:0] bin_exp;
  } vec_t;
  vec_t vecs [6];

  int base_w, base_d, errs;

  initial begin
    vecs[0] = '{8'h10, 8'h20, 8'd0, 8'h10, 8'hFF};
    vecs[1] = '{8'h48, 8'h01, 8'd1, 8'h48, 8'hFF};
    vecs[2] = '{8'h49, 8'h02, 8'd2, 8'h49, 8'h00};
    vecs[3] = '{8'h00, 8'hFF, 8'd3, 8'h00, 8'hFF};
    vecs[4] = '{8'hFF, 8'h00, 8'd4, 8'hFF, 8'h00};
    vecs[5] = '{8'h7F, 8'h33, 8'd5, 8'h7F, 8'h00};

    bus.cam_pclk_en = 1'b0; bus.cam_vsync = 1'b0; bus.cam_href = 1'b0;
    bus.cam_data = 8'h00; bus.capture_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset fb_we", {31'd0, bus.fb_we}, 32'd0);
    check("reset fb_addr", {24'd0, bus.fb_addr}, 32'd0);
    check("reset fb_wdata", {24'd0, bus.fb_wdata}, 32'd0);
    check("reset frame_done", {31'd0, bus.frame_done}, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset frame_count", {24'd0, bus.frame_count}, 32'd0);
    rst = 1'b0;

    // Table-driven row 0: Y at even column stored one Clk later, odd column and chroma not.
    bus.capture_en = 1'b1;
    frame_open();
    check("busy in frame", {31'd0, s_busy}, 32'd1);
    base_w = wr_total;
    foreach (vecs[i]) begin
      strobe(1'b0, 1'b1, vecs[i].y);
      check("vec we", {31'd0, s_we}, 32'd1);
      check("vec addr", {24'd0, s_addr}, {24'd0, vecs[i].addr});
      check("vec data", {24'd0, s_data}, {24'd0, BIN ? vecs[i].bin_exp : vecs[i].raw_exp});
      strobe(1'b0, 1'b1, 8'h80);
      check("chroma no write", {31'd0, s_we}, 32'd0);
      strobe(1'b0, 1'b1, vecs[i].y_odd);
      check("odd col no write", {31'd0, s_we}, 32'd0);
      strobe(1'b0, 1'b1, 8'h80);
    end
    strobe(1'b0, 1'b0, 8'h00);
    check("table writes", wr_total - base_w, 32'd6);
    strobe(1'b1, 1'b0, 8'h00);
    check("short frame done", {31'd0, s_done}, 32'd1);
    check("count after short", {24'd0, bus.frame_count}, 32'd1);

    // Full frame, Y = camera row.
    base_w = wr_total; base_d = done_total;
    frame_open();
    for (int r = 0; r < TH; r++) send_line(TW, 8'(r));
    strobe(1'b1, 1'b0, 8'h00);
    check("full done pulse", {31'd0, s_done}, 32'd1);
    check("full writes", wr_total - base_w, DW * DH);
    check("full addr0", {24'd0, mem[0]}, 32'd0);
    check("full addr DW", {24'd0, mem[DW]}, 32'd2);
    check("full last addr", {24'd0, mem[DW*DH-1]}, TH - 2);
    errs = 0;
    for (int a = 0; a < DW * DH; a++) if (mem[a] !== 8'(2 * (a / DW))) errs++;
    check("full sweep", errs, 32'd0);
    @(negedge clk); #1;
    check("full done once", done_total - base_d, 32'd1);
    check("count after full", {24'd0, bus.frame_count}, 32'd2);

    // Overlong line, then row 2 restarts at its base; line end and vsync share a strobe.
    frame_open();
    base_w = wr_total;
    send_line(TW + 8, 8'h33);
    check("long line writes", wr_total - base_w, DW);
    check("long line last addr", {24'd0, last_wa}, DW - 1);
    send_line(4, 8'h44);
    check("odd row no writes", wr_total - base_w, DW);
    strobe(1'b0, 1'b1, 8'h55);
    check("row2 we", {31'd0, s_we}, 32'd1);
    check("row2 addr", {24'd0, s_addr}, DW);
    check("row2 data", {24'd0, s_data}, BIN ? 32'h00 : 32'h55);
    strobe(1'b0, 1'b1, 8'h80);
    strobe(1'b1, 1'b0, 8'h00);
    check("joint end done", {31'd0, s_done}, 32'd1);
    check("count after joint", {24'd0, bus.frame_count}, 32'd3);

    // capture_en dropped mid-frame: frame completes, then FSM idles.
    frame_open();
    send_line(4, 8'h00);
    send_line(4, 8'h01);
    bus.capture_en = 1'b0;
    send_line(4, 8'h02);
    send_line(4, 8'h03);
    strobe(1'b1, 1'b0, 8'h00);
    check("drop done", {31'd0, s_done}, 32'd1);
    check("drop idle busy", {31'd0, s_busy}, 32'd0);
    check("count after drop", {24'd0, bus.frame_count}, 32'd4);
    base_w = wr_total; base_d = done_total;
    strobe(1'b0, 1'b0, 8'h00);
    send_line(4, 8'h11);
    strobe(1'b1, 1'b0, 8'h00);
    strobe(1'b0, 1'b0, 8'h00);
    send_line(4, 8'h12);
    strobe(1'b1, 1'b0, 8'h00);
    check("idle no writes", wr_total - base_w, 32'd0);
    check("idle no done", done_total - base_d, 32'd0);

    // Reset held 3 cycles mid-capture.
    bus.capture_en = 1'b1;
    frame_open();
    frame_open();
    send_line(4, 8'h21);
    strobe(1'b0, 1'b1, 8'h99);
    check("pre-reset addr", {24'd0, s_addr}, 32'd1);
    base_d = done_total;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("midrst fb_we", {31'd0, bus.fb_we}, 32'd0);
    check("midrst fb_addr", {24'd0, bus.fb_addr}, 32'd0);
    check("midrst fb_wdata", {24'd0, bus.fb_wdata}, 32'd0);
    check("midrst busy", {31'd0, bus.busy}, 32'd0);
    check("midrst count", {24'd0, bus.frame_count}, 32'd0);
    rst = 1'b0;
    strobe(1'b1, 1'b0, 8'h00);
    check("post-reset no done", {31'd0, s_done}, 32'd0);
    check("post-reset not busy", {31'd0, s_busy}, 32'd0);
    strobe(1'b1, 1'b0, 8'h00);
    check("post-reset wait frame", {31'd0, s_busy}, 32'd1);
    check("reset no done pulse", done_total - base_d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
